// File: rtl/mem_if_pkg.sv
// Shared widths and state encoding for the memory access unit and its helpers.
package mem_if_pkg;

   localparam int ADR_W  = 4;
   localparam int CMD_W  = 16;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CMD_WAIT  = 2'd1,
      ST_DATA_WAIT = 2'd2,
      ST_STORE     = 2'd3
   } mau_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for the access unit: cleared on request issue, counts while waiting,
// and raises hit once TIMEOUT wait cycles have gone by without a response.
module mem_timeout_cnt #(
   parameter int TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates at TIMEOUT so a stalled enable can never wrap back to a small count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the instruction/data memory handshake; one outstanding transaction,
// registered strobes towards memory and registered result pulses towards the core.
module mem_access_unit
   import mem_if_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADR_W-1:0]  fetch_adr,
   input  logic              ld_req,
   input  logic [ADR_W-1:0]  ld_adr,
   input  logic              st_req,
   input  logic [DATA_W-1:0] st_data,
   output logic              busy,
   output logic              instr_valid,
   output logic [CMD_W-1:0]  instr,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_data,
   output logic              st_done,
   output logic              timeout_err,
   output logic              giveC,
   output logic              giveD,
   output logic              write_data,
   output logic [ADR_W-1:0]  ADR_1,
   input  logic [CMD_W-1:0]  com,
   input  logic [DATA_W-1:0] data_t,
   input  logic              dv
);

   mau_state_t        state_q, state_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic [CMD_W-1:0]  instr_q, instr_d;
   logic [DATA_W-1:0] ld_data_q, ld_data_d;
   logic              give_c_q, give_c_d;
   logic              give_d_q, give_d_d;
   logic              write_q, write_d;
   logic              instr_valid_q, instr_valid_d;
   logic              ld_valid_q, ld_valid_d;
   logic              st_done_q, st_done_d;
   logic              timeout_err_q, timeout_err_d;
   logic              cnt_clear, cnt_hit, pulse_any;

   assign pulse_any = instr_valid_q | ld_valid_q | st_done_q | timeout_err_q;

   mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable ((state_q == ST_CMD_WAIT) || (state_q == ST_DATA_WAIT)),
      .hit    (cnt_hit)
   );

   // Requests are only taken once the previous result pulse has cleared, so busy covers it too.
   always_comb begin
      state_d       = state_q;
      adr_d         = adr_q;
      instr_d       = instr_q;
      ld_data_d     = ld_data_q;
      give_c_d      = 1'b0;
      give_d_d      = 1'b0;
      write_d       = 1'b0;
      instr_valid_d = 1'b0;
      ld_valid_d    = 1'b0;
      st_done_d     = 1'b0;
      timeout_err_d = 1'b0;
      cnt_clear     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!pulse_any) begin
               if (st_req) begin
                  adr_d   = st_data;
                  write_d = 1'b1;
                  state_d = ST_STORE;
               end else if (ld_req) begin
                  adr_d     = ld_adr;
                  give_d_d  = 1'b1;
                  cnt_clear = 1'b1;
                  state_d   = ST_DATA_WAIT;
               end else if (fetch_req) begin
                  adr_d     = fetch_adr;
                  give_c_d  = 1'b1;
                  cnt_clear = 1'b1;
                  state_d   = ST_CMD_WAIT;
               end
            end
         end
         ST_CMD_WAIT: begin
            if (dv) begin
               instr_d       = com;
               instr_valid_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (cnt_hit) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_DATA_WAIT: begin
            if (dv) begin
               ld_data_d  = data_t;
               ld_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end else if (cnt_hit) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_STORE: begin
            st_done_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         adr_q         <= '0;
         instr_q       <= '0;
         ld_data_q     <= '0;
         give_c_q      <= 1'b0;
         give_d_q      <= 1'b0;
         write_q       <= 1'b0;
         instr_valid_q <= 1'b0;
         ld_valid_q    <= 1'b0;
         st_done_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         adr_q         <= adr_d;
         instr_q       <= instr_d;
         ld_data_q     <= ld_data_d;
         give_c_q      <= give_c_d;
         give_d_q      <= give_d_d;
         write_q       <= write_d;
         instr_valid_q <= instr_valid_d;
         ld_valid_q    <= ld_valid_d;
         st_done_q     <= st_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE) | pulse_any;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign ld_valid    = ld_valid_q;
   assign ld_data     = ld_data_q;
   assign st_done     = st_done_q;
   assign timeout_err = timeout_err_q;
   assign giveC       = give_c_q;
   assign giveD       = give_d_q;
   assign write_data  = write_q;
   assign ADR_1       = adr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus hand sequences, with a
// scoreboard of expected result pulses consumed by a monitor.
module tb_mem_access_unit;
   import mem_if_pkg::*;

   localparam int TIMEOUT = 8;

   typedef enum logic [1:0] {K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_TIMEOUT = 2'd3} kind_t;

   typedef struct {
      kind_t       kind;
      logic [3:0]  adr;
      logic [15:0] resp;
      logic [3:0]  expAdr;
      logic [15:0] expResult;
   } vec_t;

   typedef struct {
      kind_t       kind;
      logic [15:0] val;
   } sb_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_req, ld_req, st_req;
   logic [ADR_W-1:0]  fetch_adr, ld_adr;
   logic [DATA_W-1:0] st_data;
   logic              busy, instr_valid, ld_valid, st_done, timeout_err;
   logic [CMD_W-1:0]  instr;
   logic [DATA_W-1:0] ld_data;
   logic              giveC, giveD, write_data;
   logic [ADR_W-1:0]  ADR_1;
   logic [CMD_W-1:0]  com;
   logic [DATA_W-1:0] data_t;
   logic              dv;

   int          nChecks = 0;
   int          nFails  = 0;
   sb_t         sbQ[$];
   logic [15:0] lastInstr = 16'h0;
   vec_t        vecs[6];

   mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_adr   (fetch_adr),
      .ld_req      (ld_req),
      .ld_adr      (ld_adr),
      .st_req      (st_req),
      .st_data     (st_data),
      .busy        (busy),
      .instr_valid (instr_valid),
      .instr       (instr),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .st_done     (st_done),
      .timeout_err (timeout_err),
      .giveC       (giveC),
      .giveD       (giveD),
      .write_data  (write_data),
      .ADR_1       (ADR_1),
      .com         (com),
      .data_t      (data_t),
      .dv          (dv)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      if (busy) checkOutput("idle_wait_expired", 32'(busy), 32'h0);
   endtask

   // Every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if ((32'(instr_valid) + 32'(ld_valid) + 32'(st_done) + 32'(timeout_err)) > 1)
            checkOutput("single_pulse", {28'h0, instr_valid, ld_valid, st_done, timeout_err}, 32'h0);
         else if (instr_valid || ld_valid || st_done || timeout_err) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_pulse", {28'h0, instr_valid, ld_valid, st_done, timeout_err}, 32'h0);
            end else begin
               sb_t e;
               e = sbQ.pop_front();
               case (e.kind)
                  K_FETCH: begin
                     checkOutput("instr_valid", 32'(instr_valid), 32'h1);
                     checkOutput("instr", 32'(instr), 32'(e.val));
                     lastInstr = e.val;
                  end
                  K_LOAD: begin
                     checkOutput("ld_valid", 32'(ld_valid), 32'h1);
                     checkOutput("ld_data", 32'(ld_data), 32'(e.val[3:0]));
                     checkOutput("instr_kept", 32'(instr), 32'(lastInstr));
                  end
                  K_STORE:   checkOutput("st_done", 32'(st_done), 32'h1);
                  K_TIMEOUT: checkOutput("timeout_err", 32'(timeout_err), 32'h1);
                  default:   checkOutput("sb_kind", 32'(e.kind), 32'h0);
               endcase
            end
         end
      end
   end

   task automatic applyStimulus(input vec_t v);
      waitIdle();
      case (v.kind)
         K_FETCH: begin fetch_req = 1'b1; fetch_adr = v.adr; end
         K_LOAD:  begin ld_req = 1'b1; ld_adr = v.adr; end
         default: begin st_req = 1'b1; st_data = v.adr; end
      endcase
      sbQ.push_back('{kind: v.kind, val: v.expResult});
      tick();
      fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      checkOutput("giveC", 32'(giveC), 32'(v.kind == K_FETCH));
      checkOutput("giveD", 32'(giveD), 32'(v.kind == K_LOAD));
      checkOutput("write_data", 32'(write_data), 32'(v.kind == K_STORE));
      checkOutput("ADR_1", 32'(ADR_1), 32'(v.expAdr));
      tick();
      checkOutput("strobe_one_cycle", {29'h0, giveC, giveD, write_data}, 32'h0);
      if (v.kind == K_STORE) begin
         checkOutput("st_done_timing", 32'(st_done), 32'h1);
      end else begin
         checkOutput("ADR_1_held", 32'(ADR_1), 32'(v.expAdr));
         dv = 1'b1; com = v.resp; data_t = v.resp[3:0];
         tick();
         dv = 1'b0; com = 16'hDEAD; data_t = 4'h0;
         checkOutput("read_latency", 32'(v.kind == K_FETCH ? instr_valid : ld_valid), 32'h1);
         tick();
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{kind: K_FETCH, adr: 4'h1, resp: 16'h0247, expAdr: 4'h1, expResult: 16'h0247};
      vecs[1] = '{kind: K_LOAD,  adr: 4'h2, resp: 16'h0003, expAdr: 4'h2, expResult: 16'h0003};
      vecs[2] = '{kind: K_STORE, adr: 4'h5, resp: 16'h0000, expAdr: 4'h5, expResult: 16'h0000};
      vecs[3] = '{kind: K_FETCH, adr: 4'hF, resp: 16'hBEEF, expAdr: 4'hF, expResult: 16'hBEEF};
      vecs[4] = '{kind: K_LOAD,  adr: 4'hA, resp: 16'h000C, expAdr: 4'hA, expResult: 16'h000C};
      vecs[5] = '{kind: K_STORE, adr: 4'hA, resp: 16'h0000, expAdr: 4'hA, expResult: 16'h0000};

      rst = 1'b1;
      fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      fetch_adr = '0; ld_adr = '0; st_data = '0;
      com = 16'hDEAD; data_t = 4'h0; dv = 1'b0;
      tick(); tick();
      checkOutput("reset_outputs", {busy, instr_valid, ld_valid, st_done, timeout_err, giveC, giveD, write_data}, 32'h0);
      checkOutput("reset_regs", {instr, ld_data, ADR_1}, 32'h0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Simultaneous requests: only the store may go out.
      waitIdle();
      st_req = 1'b1; ld_req = 1'b1; fetch_req = 1'b1;
      st_data = 4'h5; ld_adr = 4'h2; fetch_adr = 4'h1;
      sbQ.push_back('{kind: K_STORE, val: 16'h0});
      tick();
      st_req = 1'b0; ld_req = 1'b0; fetch_req = 1'b0;
      checkOutput("prio_strobes", {29'h0, giveC, giveD, write_data}, 32'h1);
      checkOutput("prio_ADR_1", 32'(ADR_1), 32'h5);
      tick();
      checkOutput("prio_st_done", 32'(st_done), 32'h1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("prio_no_read", {30'h0, giveC, giveD}, 32'h0);
         tick();
      end

      // Silent responder: abort after TIMEOUT wait cycles, late dv ignored.
      waitIdle();
      fetch_req = 1'b1; fetch_adr = 4'h3;
      sbQ.push_back('{kind: K_TIMEOUT, val: 16'h0});
      tick();
      fetch_req = 1'b0;
      checkOutput("to_giveC", 32'(giveC), 32'h1);
      for (int i = 0; i < TIMEOUT; i++) tick();
      checkOutput("to_not_early", 32'(timeout_err), 32'h0);
      checkOutput("to_busy", 32'(busy), 32'h1);
      tick();
      checkOutput("to_pulse", 32'(timeout_err), 32'h1);
      dv = 1'b1; com = 16'hFFFF; data_t = 4'hF;
      tick();
      dv = 1'b0; com = 16'hDEAD; data_t = 4'h0;
      checkOutput("late_dv_ignored", {instr_valid, ld_valid, busy, instr}, {3'b000, lastInstr});
      applyStimulus('{kind: K_FETCH, adr: 4'h9, resp: 16'hA5A5, expAdr: 4'h9, expResult: 16'hA5A5});

      // Requests while busy (in flight, and during the result pulse) are dropped.
      waitIdle();
      fetch_req = 1'b1; fetch_adr = 4'h6;
      sbQ.push_back('{kind: K_FETCH, val: 16'h1234});
      tick();
      checkOutput("busy_first_giveC", 32'(giveC), 32'h1);
      fetch_adr = 4'h7;
      tick();
      fetch_req = 1'b0;
      checkOutput("busy_no_second_giveC", 32'(giveC), 32'h0);
      dv = 1'b1; com = 16'h1234;
      tick();
      dv = 1'b0; com = 16'hDEAD;
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      checkOutput("pulse_busy_no_giveC", 32'(giveC), 32'h0);
      checkOutput("busy_ADR_1", 32'(ADR_1), 32'h6);
      tick();
      checkOutput("busy_idle_after", {busy, giveC}, 32'h0);

      // Reset mid-read: everything clears and the pending response is lost.
      fetch_req = 1'b1; fetch_adr = 4'h7;
      tick();
      fetch_req = 1'b0;
      checkOutput("rst_seq_giveC", 32'(giveC), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lastInstr = 16'h0;
      checkOutput("rst_mid_outputs", {busy, instr_valid, ld_valid, st_done, timeout_err, giveC, giveD, write_data}, 32'h0);
      checkOutput("rst_mid_regs", {instr, ld_data, ADR_1}, 32'h0);
      dv = 1'b1; com = 16'h5555;
      tick();
      dv = 1'b0; com = 16'hDEAD;
      tick();
      checkOutput("rst_dv_ignored", {instr_valid, busy, instr}, 32'h0);

      repeat (3) tick();
      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
